fb_access_sequencer: RTL and testbench

Owns the single shared read/write port of the 16-row x 32-bit monochrome framebuffer in the baby VGA peripheral. It arbitrates between CPU bus word accesses and a hardware scroll engine. The scroll engine moves every row up or down by one and fills the vacated row with a pattern. The display scan-out port is separate and not handled here.

---
 rtl/fb_access_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_fb_access_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fb_access_sequencer
// Description : Owner of the single shared read/write port of the row-based
//               monochrome framebuffer. Arbitrates CPU word accesses against
//               a hardware scroll engine that shifts every row up or down by
//               one and fills the vacated row with a pattern.
//               Optional macro VBLANK_GATE_EN: framebuffer writes wait for
//               vblank=1 (reads are never gated).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_access_sequencer #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_write,
  input  logic              cpu_read,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cpu_overflow,
  input  logic              scroll_req,
  input  logic              scroll_dir,
  input  logic [31:0]       scroll_fill,
  output logic              scroll_busy,
  output logic              scroll_done,
  input  logic              vblank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wdata,
  output logic              fb_we,
  output logic              fb_re,
  input  logic [31:0]       fb_rdata
);

  localparam logic [ADDR_W-1:0] c_last_row  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] c_last_move = ADDR_W'(ROWS - 2);
  localparam logic [3:0]        c_rd_lat    = 4'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CPU_WR   = 3'd1,
    S_CPU_RD   = 3'd2,
    S_CPU_WAIT = 3'd3,
    S_SC_RD    = 3'd4,
    S_SC_WAIT  = 3'd5,
    S_SC_WR    = 3'd6,
    S_SC_FILL  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  // Pending CPU slot (one request deep)
  logic              r_slot_full;
  logic              r_slot_wr;
  logic [ADDR_W-1:0] r_slot_addr;
  logic [31:0]       r_slot_wdata;
  logic              r_ovf;
  logic [31:0]       r_cpu_rdata;

  // Read latency counter shared by CPU and scroll reads
  logic [3:0]        r_cnt;

  // Scroll engine context; survives CPU interleaves
  logic              r_sc_busy;
  logic              r_sc_dir;
  logic [31:0]       r_sc_fill;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_moves;
  logic [31:0]       r_row;

  logic              w_req_any;
  logic              w_accept;
  logic              w_drop;
  logic              w_sc_accept;
  logic              w_cpu_pend;
  logic              w_pend_wr;
  logic [ADDR_W-1:0] w_src;
  logic              w_rd_done;
  logic              w_last_move;
  logic              w_cpu_done;
  logic              w_slot_clr;
  logic              w_wr_ok;

`ifdef VBLANK_GATE_EN
  assign w_wr_ok = vblank;
`else
  // vblank has no effect in this build; writes always proceed
  assign w_wr_ok = vblank | 1'b1;
`endif

  assign w_req_any   = cpu_write | cpu_read;
  assign w_accept    = w_req_any & ~r_slot_full;
  // A write+read pair keeps the write, so the read counts as dropped
  assign w_drop      = (w_req_any & r_slot_full) | (cpu_write & cpu_read);
  assign w_sc_accept = scroll_req & ~r_sc_busy;
  // The arbiter also sees a request in its arrival cycle to meet N+1 latency
  assign w_cpu_pend  = r_slot_full | w_accept;
  assign w_pend_wr   = r_slot_full ? r_slot_wr : cpu_write;
  assign w_src       = r_sc_dir ? (r_dst - 1'b1) : (r_dst + 1'b1);
  assign w_rd_done   = (r_cnt == c_rd_lat);
  assign w_last_move = (r_moves == c_last_move);
  assign w_cpu_done  = (r_state == S_CPU_WAIT) & w_rd_done;
  assign w_slot_clr  = ((r_state == S_CPU_WR) & w_wr_ok) | w_cpu_done;

  assign cpu_busy     = r_slot_full;
  assign cpu_overflow = r_ovf;
  assign scroll_busy  = r_sc_busy;
  // Read data is forwarded in the ready cycle and held afterwards
  assign cpu_rdata    = w_cpu_done ? fb_rdata : r_cpu_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and framebuffer strobe decode
  always_comb begin
    w_next      = r_state;
    fb_we       = 1'b0;
    fb_re       = 1'b0;
    fb_addr     = '0;
    fb_wdata    = '0;
    cpu_ready   = 1'b0;
    scroll_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_pend)     w_next = w_pend_wr ? S_CPU_WR : S_CPU_RD;
        else if (r_sc_busy) w_next = S_SC_RD;
      end
      S_CPU_WR: begin
        fb_addr  = r_slot_addr;
        fb_wdata = r_slot_wdata;
        if (w_wr_ok) begin
          fb_we  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_CPU_RD: begin
        fb_re   = 1'b1;
        fb_addr = r_slot_addr;
        w_next  = S_CPU_WAIT;
      end
      S_CPU_WAIT: begin
        if (w_rd_done) begin
          cpu_ready = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_SC_RD: begin
        fb_re   = 1'b1;
        fb_addr = w_src;
        w_next  = S_SC_WAIT;
      end
      S_SC_WAIT: begin
        if (w_rd_done) w_next = S_SC_WR;
      end
      S_SC_WR: begin
        fb_addr  = r_dst;
        fb_wdata = r_row;
        if (w_wr_ok) begin
          fb_we = 1'b1;
          // CPU traffic may only slip in here, between complete moves
          if (w_last_move)     w_next = S_SC_FILL;
          else if (w_cpu_pend) w_next = S_IDLE;
          else                 w_next = S_SC_RD;
        end
      end
      S_SC_FILL: begin
        fb_addr  = r_sc_dir ? '0 : c_last_row;
        fb_wdata = r_sc_fill;
        if (w_wr_ok) begin
          fb_we       = 1'b1;
          scroll_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // CPU request slot, sticky overflow and read-data hold register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_full  <= 1'b0;
      r_slot_wr    <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_wdata <= '0;
      r_ovf        <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      if (w_slot_clr) r_slot_full <= 1'b0;
      if (w_accept) begin
        r_slot_full  <= 1'b1;
        r_slot_wr    <= cpu_write;
        r_slot_addr  <= cpu_addr;
        r_slot_wdata <= cpu_wdata;
      end
      if (w_drop)     r_ovf       <= 1'b1;
      if (w_cpu_done) r_cpu_rdata <= fb_rdata;
    end
  end

  // Read latency counter: the first wait cycle counts as 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_CPU_RD) || (r_state == S_SC_RD)) begin
      r_cnt <= 4'd1;
    end else if ((r_state == S_CPU_WAIT) || (r_state == S_SC_WAIT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Scroll engine context: start capture, row latch and move stepping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc_busy <= 1'b0;
      r_sc_dir  <= 1'b0;
      r_sc_fill <= '0;
      r_dst     <= '0;
      r_moves   <= '0;
      r_row     <= '0;
    end else begin
      if (w_sc_accept) begin
        r_sc_busy <= 1'b1;
        r_sc_dir  <= scroll_dir;
        r_sc_fill <= scroll_fill;
        r_dst     <= scroll_dir ? c_last_row : '0;
        r_moves   <= '0;
      end
      if ((r_state == S_SC_WAIT) && w_rd_done) r_row <= fb_rdata;
      // The index is not stepped after the final move so it never wraps
      if ((r_state == S_SC_WR) && w_wr_ok && !w_last_move) begin
        r_moves <= r_moves + 1'b1;
        r_dst   <= w_src;
      end
      if ((r_state == S_SC_FILL) && w_wr_ok) r_sc_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_access_sequencer
// Description : Self-checking bench for fb_access_sequencer with a behavioural
//               framebuffer model and write/read scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_access_sequencer;
  localparam int ROWS   = 16;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_write, cpu_read;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready, cpu_busy, cpu_overflow;
  logic              scroll_req, scroll_dir;
  logic [31:0]       scroll_fill;
  logic              scroll_busy, scroll_done;
  logic              vblank;
  logic [ADDR_W-1:0] fb_addr;
  logic [31:0]       fb_wdata;
  logic              fb_we, fb_re;
  logic [31:0]       fb_rdata;

  fb_access_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cpu_overflow(cpu_overflow),
    .scroll_req(scroll_req), .scroll_dir(scroll_dir), .scroll_fill(scroll_fill),
    .scroll_busy(scroll_busy), .scroll_done(scroll_done), .vblank(vblank),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_re(fb_re), .fb_rdata(fb_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } ev_t;

  ev_t         ev_log[$];
  logic [35:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [35:0] e_wr;
  logic [31:0] e_rd;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  bit          sb_en = 1'b1;

  // Framebuffer model: write on fb_we, read data RD_LAT cycles after fb_re
  logic [31:0] mem    [ROWS];
  logic        pipe_v [RD_LAT];
  logic [31:0] pipe_d [RD_LAT];

  always @(posedge clk) begin
    if (fb_we === 1'b1) mem[fb_addr] <= fb_wdata;
    pipe_v[0] <= (fb_re === 1'b1);
    pipe_d[0] <= mem[fb_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign fb_rdata = (pipe_v[RD_LAT-1] === 1'b1) ? pipe_d[RD_LAT-1] : 32'hBAD0BAD0;

  // Monitor: strobe exclusivity, write/read scoreboards, event log
  always @(negedge clk) begin
    #4;
    if (rst_n === 1'b1) begin
      n_checks++;
      if (fb_we === 1'b1 && fb_re === 1'b1) begin
        n_errors++;
        $display("FAIL strobe_excl: fb_we=%b fb_re=%b both high, required not both", fb_we, fb_re);
      end
      if (fb_we === 1'b1) begin
        ev_log.push_back(ev_t'({1'b1, fb_addr, fb_wdata}));
        if (sb_en) begin
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_errors++;
            $display("FAIL fb_write: unexpected write addr=%0d data=%h, required no write", fb_addr, fb_wdata);
          end else begin
            e_wr = exp_wr.pop_front();
            if ({fb_addr, fb_wdata} !== e_wr) begin
              n_errors++;
              $display("FAIL fb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                       fb_addr, fb_wdata, e_wr[35:32], e_wr[31:0]);
            end
          end
        end
      end
      if (fb_re === 1'b1) ev_log.push_back(ev_t'({1'b0, fb_addr, 32'h0}));
      if (cpu_ready === 1'b1) begin
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_errors++;
          $display("FAIL cpu_read: unexpected cpu_ready data=%h, required none", cpu_rdata);
        end else begin
          e_rd = exp_rd.pop_front();
          if (cpu_rdata !== e_rd) begin
            n_errors++;
            $display("FAIL cpu_read: got %h, required %h", cpu_rdata, e_rd);
          end
        end
      end
      if (scroll_done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0; scroll_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    tick();
    cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
    exp_wr.push_back({a, d});
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic preload();
    for (int r = 0; r < ROWS; r++) drive_write(ADDR_W'(r), 32'(r));
    tick();
  endtask

  task automatic wait_scroll_idle();
    int k;
    k = 0;
    while (scroll_busy === 1'b1 && k < 600) begin tick(); k++; end
    n_checks++;
    if (k >= 600) begin
      n_errors++;
      $display("FAIL scroll_timeout: scroll_busy=%b after %0d cycles, required 0", scroll_busy, k);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (fb_we !== 1'b0 || fb_re !== 1'b0) begin
      n_errors++; $display("FAIL reset_strobes: we=%b re=%b, required 0 0", fb_we, fb_re);
    end
    n_checks++;
    if ({cpu_busy, cpu_ready, cpu_overflow} !== 3'b000) begin
      n_errors++; $display("FAIL reset_cpu_flags: %b, required 000", {cpu_busy, cpu_ready, cpu_overflow});
    end
    n_checks++;
    if ({scroll_busy, scroll_done} !== 2'b00) begin
      n_errors++; $display("FAIL reset_scroll_flags: %b, required 00", {scroll_busy, scroll_done});
    end
    n_checks++;
    if (cpu_rdata !== 32'h0 || fb_addr !== '0 || fb_wdata !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: rdata=%h addr=%0d wdata=%h, required 0", cpu_rdata, fb_addr, fb_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write();
    tick();
    cpu_write = 1'b1; cpu_addr = 4'd3; cpu_wdata = 32'hDEADBEEF;
    exp_wr.push_back({4'd3, 32'hDEADBEEF});
    tick();
    cpu_write = 1'b0;
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 4'd3 || fb_wdata !== 32'hDEADBEEF || cpu_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_latency: we=%b addr=%0d data=%h busy=%b, required 1 3 deadbeef 1", fb_we, fb_addr, fb_wdata, cpu_busy);
    end
    tick();
    n_checks++;
    if (cpu_busy !== 1'b0 || fb_we !== 1'b0) begin
      n_errors++; $display("FAIL wr_busy_fall: busy=%b we=%b, required 0 0", cpu_busy, fb_we);
    end
    n_checks++;
    if (mem[3] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL wr_mem: row3=%h, required deadbeef", mem[3]);
    end
  endtask

  task automatic test_cpu_read();
    int k;
    drive_write(4'd5, 32'h12345678);
    tick();
    tick();
    cpu_read = 1'b1; cpu_addr = 4'd5;
    exp_rd.push_back(32'h12345678);
    tick();
    cpu_read = 1'b0;
    n_checks++;
    if (fb_re !== 1'b1 || fb_addr !== 4'd5) begin
      n_errors++; $display("FAIL rd_strobe: re=%b addr=%0d, required 1 5", fb_re, fb_addr);
    end
    k = 0;
    while (k < 30) begin
      tick(); k++;
      if (cpu_ready === 1'b1) break;
    end
    n_checks++;
    if (k != RD_LAT) begin
      n_errors++; $display("FAIL rd_latency: ready after %0d cycles, required %0d", k, RD_LAT);
    end
    tick();
    n_checks++;
    if (cpu_rdata !== 32'h12345678 || cpu_ready !== 1'b0 || cpu_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_hold: rdata=%h ready=%b busy=%b, required 12345678 0 0", cpu_rdata, cpu_ready, cpu_busy);
    end
  endtask

  task automatic test_scroll(input logic dir, input logic [31:0] fill);
    int d0;
    logic [31:0] exp_row;
    preload();
    for (int m = 0; m < ROWS - 1; m++) begin
      if (!dir) exp_wr.push_back({4'(m), 32'(m + 1)});
      else      exp_wr.push_back({4'(ROWS - 1 - m), 32'(ROWS - 2 - m)});
    end
    exp_wr.push_back({(dir ? 4'd0 : 4'(ROWS - 1)), fill});
    d0 = done_cnt;
    tick();
    scroll_req = 1'b1; scroll_dir = dir; scroll_fill = fill;
    tick();
    scroll_req = 1'b0; scroll_fill = 32'h0;
    n_checks++;
    if (scroll_busy !== 1'b1) begin
      n_errors++; $display("FAIL sc_busy_dir%0d: scroll_busy=%b, required 1", dir, scroll_busy);
    end
    wait_scroll_idle();
    n_checks++;
    if (done_cnt != d0 + 1 || exp_wr.size() != 0) begin
      n_errors++;
      $display("FAIL sc_done_dir%0d: done pulses=%0d pending writes=%0d, required 1 0", dir, done_cnt - d0, exp_wr.size());
    end
    for (int r = 0; r < ROWS; r++) begin
      if (!dir) exp_row = (r == ROWS - 1) ? fill : 32'(r + 1);
      else      exp_row = (r == 0) ? fill : 32'(r - 1);
      n_checks++;
      if (mem[r] !== exp_row) begin
        n_errors++; $display("FAIL sc_row_dir%0d: row %0d=%h, required %h", dir, r, mem[r], exp_row);
      end
    end
  endtask

  task automatic test_interleave();
    int k, nw, idx;
    bit split;
    logic [31:0] exp_row;
    preload();
    sb_en = 1'b0;
    ev_log.delete();
    tick();
    scroll_req = 1'b1; scroll_dir = 1'b0; scroll_fill = 32'hFFFFFFFF;
    tick();
    scroll_req = 1'b0;
    k = 0; nw = 0;
    while (nw < 3 && k < 200) begin
      tick(); k++;
      nw = 0;
      foreach (ev_log[i]) if (ev_log[i].we) nw++;
    end
    tick();
    cpu_write = 1'b1; cpu_addr = 4'd0; cpu_wdata = 32'hA5A5A5A5;
    tick();
    cpu_write = 1'b0;
    wait_scroll_idle();
    idx = -1;
    foreach (ev_log[i]) if (ev_log[i].we && ev_log[i].addr == 4'd0 && ev_log[i].data == 32'hA5A5A5A5) idx = i;
    n_checks++;
    if (idx < 1 || idx + 1 >= ev_log.size()) begin
      n_errors++; $display("FAIL il_found: cpu write index=%0d, required inside scroll", idx);
    end else begin
      n_checks++;
      if (ev_log[idx-1].we !== 1'b1 || ev_log[idx+1].we !== 1'b0) begin
        n_errors++;
        $display("FAIL il_position: prev we=%b next we=%b, required 1 0", ev_log[idx-1].we, ev_log[idx+1].we);
      end
    end
    split = 1'b0;
    for (int i = 0; i < ev_log.size(); i++)
      if (!ev_log[i].we && (i + 1 >= ev_log.size() || !ev_log[i+1].we)) split = 1'b1;
    n_checks++;
    if (split) begin
      n_errors++; $display("FAIL il_move_split: read not followed by write=%b, required 0", split);
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_row = (r == 0) ? 32'hA5A5A5A5 : (r == ROWS - 1) ? 32'hFFFFFFFF : 32'(r + 1);
      n_checks++;
      if (mem[r] !== exp_row) begin
        n_errors++; $display("FAIL il_row: row %0d=%h, required %h", r, mem[r], exp_row);
      end
    end
    sb_en = 1'b1;
  endtask

  task automatic test_same_cycle();
    tick();
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 4'd9; cpu_wdata = 32'h0000_55AA;
    exp_wr.push_back({4'd9, 32'h0000_55AA});
    tick();
    cpu_write = 1'b0; cpu_read = 1'b0;
    repeat (RD_LAT + 3) tick();
    n_checks++;
    if (cpu_overflow !== 1'b1 || mem[9] !== 32'h0000_55AA || exp_wr.size() != 0) begin
      n_errors++;
      $display("FAIL same_cycle: ovf=%b row9=%h pending=%0d, required 1 000055aa 0", cpu_overflow, mem[9], exp_wr.size());
    end
  endtask

  task automatic test_overflow();
    int k;
    do_reset();
    n_checks++;
    if (cpu_overflow !== 1'b0) begin
      n_errors++; $display("FAIL ovf_reset_clear: ovf=%b, required 0", cpu_overflow);
    end
    drive_write(4'd2, 32'h0BADF00D);
    tick();
    tick();
    cpu_read = 1'b1; cpu_addr = 4'd2;
    exp_rd.push_back(32'h0BADF00D);
    tick();
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 4'd7; cpu_wdata = 32'h1;
    tick();
    cpu_wdata = 32'h2;
    tick();
    cpu_write = 1'b0;
    n_checks++;
    if (cpu_overflow !== 1'b1 || cpu_busy !== 1'b1) begin
      n_errors++; $display("FAIL ovf_set: ovf=%b busy=%b, required 1 1", cpu_overflow, cpu_busy);
    end
    k = 0;
    while (exp_rd.size() != 0 && k < 40) begin tick(); k++; end
    repeat (4) tick();
    n_checks++;
    if (exp_rd.size() != 0 || cpu_overflow !== 1'b1 || cpu_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_sticky: pending reads=%0d ovf=%b busy=%b, required 0 1 0", exp_rd.size(), cpu_overflow, cpu_busy);
    end
    do_reset();
    n_checks++;
    if (cpu_overflow !== 1'b0) begin
      n_errors++; $display("FAIL ovf_cleared: ovf=%b, required 0", cpu_overflow);
    end
  endtask

  task automatic test_vblank();
    vblank = 1'b0;
    tick();
    cpu_write = 1'b1; cpu_addr = 4'd6; cpu_wdata = 32'h600D600D;
    exp_wr.push_back({4'd6, 32'h600D600D});
    tick();
    cpu_write = 1'b0;
`ifdef VBLANK_GATE_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fb_we !== 1'b0 || cpu_busy !== 1'b1) begin
        n_errors++; $display("FAIL vb_stall: we=%b busy=%b, required 0 1", fb_we, cpu_busy);
      end
      tick();
    end
    vblank = 1'b1;
    #1;
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 4'd6) begin
      n_errors++; $display("FAIL vb_release: we=%b addr=%0d, required 1 6", fb_we, fb_addr);
    end
`else
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 4'd6) begin
      n_errors++; $display("FAIL vb_ignored: we=%b addr=%0d, required 1 6", fb_we, fb_addr);
    end
`endif
    tick();
    vblank = 1'b1;
    tick();
    n_checks++;
    if (mem[6] !== 32'h600D600D || exp_wr.size() != 0) begin
      n_errors++; $display("FAIL vb_mem: row6=%h pending=%0d, required 600d600d 0", mem[6], exp_wr.size());
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    sb_en = 1'b0;
    tick();
    scroll_req = 1'b1; scroll_dir = 1'b1; scroll_fill = 32'h12121212;
    tick();
    scroll_req = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (fb_we !== 1'b0 || fb_re !== 1'b0 || scroll_busy !== 1'b0) begin
        n_errors++; bad++;
        if (bad < 4) $display("FAIL abort_quiet: we=%b re=%b sbusy=%b, required 0 0 0", fb_we, fb_re, scroll_busy);
      end
    end
    sb_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_read = 1'b0;
    scroll_req = 1'b0; scroll_dir = 1'b0; scroll_fill = '0; vblank = 1'b1;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_scroll(1'b0, 32'hFFFFFFFF);
    test_scroll(1'b1, 32'h0F0FA5A5);
    test_interleave();
    test_same_cycle();
    test_overflow();
    test_vblank();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
